// File: rtl/finalprojsoc_nios2_gen2_0_cpu_debug_monitor_pkg.sv
// Shared types and constants for the debug monitor memory stage.
package finalprojsoc_nios2_gen2_0_cpu_debug_monitor_pkg;
  localparam int RAM_AW    = 8;
  localparam int NUM_LANES = 4;

  // jdo field positions
  localparam int JDO_ADDR_LSB = 26;
  localparam int JDO_RDY_CLR  = 25;
  localparam int JDO_ERR_CLR  = 24;
  localparam int JDO_RD_REQ   = 17;
  localparam int JDO_DATA_MSB = 34;
  localparam int JDO_DATA_LSB = 3;

  // register page word offsets
  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_ADDR   = 2'd1;

  typedef enum logic [1:0] {IDLE, J_RD, J_WR, C_RD} state_t;

  typedef struct packed {
    logic                 we;
    logic                 re;
    logic [NUM_LANES-1:0] be;
    logic [RAM_AW-1:0]    addr;
    logic [31:0]          wdata;
  } ram_req_t;
endpackage

// File: rtl/finalprojsoc_nios2_gen2_0_cpu_debug_monitor_mem_if.sv
// Avalon-MM slave bus used by the CPU debug monitor code.
interface finalprojsoc_nios2_gen2_0_cpu_debug_monitor_mem_if;
  logic [8:0]  av_address;
  logic        av_read;
  logic        av_write;
  logic [31:0] av_writedata;
  logic [3:0]  av_byteenable;
  logic [31:0] av_readdata;
  logic        av_waitrequest;

  modport master (
    output av_address, av_read, av_write, av_writedata, av_byteenable,
    input  av_readdata, av_waitrequest
  );
  modport slave (
    input  av_address, av_read, av_write, av_writedata, av_byteenable,
    output av_readdata, av_waitrequest
  );
endinterface

// File: rtl/finalprojsoc_nios2_gen2_0_cpu_debug_monitor_ram.sv
// Single-port monitor RAM, synchronous read, one byte array per lane.
module finalprojsoc_nios2_gen2_0_cpu_debug_monitor_ram
  import finalprojsoc_nios2_gen2_0_cpu_debug_monitor_pkg::*;
#(
  parameter int AW = RAM_AW
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic                      re,
  input  logic [NUM_LANES-1:0]      be,
  input  logic [AW-1:0]             addr,
  input  logic [NUM_LANES-1:0][7:0] wdata,
  output logic [NUM_LANES-1:0][7:0] q
);
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [7:0] mem [2**AW];
    logic [7:0] q_l;
    // byte-lane write and registered read; q holds between reads
    always_ff @(posedge clk) begin
      if (we && be[l]) mem[addr] <= wdata[l];
      if (re) q_l <= mem[addr];
    end
    assign q[l] = q_l;
  end
endmodule

// File: rtl/finalprojsoc_nios2_gen2_0_cpu_debug_monitor_mem.sv
// JTAG/CPU arbiter, FSM and debug registers around the monitor RAM.
module finalprojsoc_nios2_gen2_0_cpu_debug_monitor_mem
  import finalprojsoc_nios2_gen2_0_cpu_debug_monitor_pkg::*;
#(
  parameter int RAM_AW = finalprojsoc_nios2_gen2_0_cpu_debug_monitor_pkg::RAM_AW
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [37:0] jdo,
  input  logic        take_action_ocimem_a,
  input  logic        take_no_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  finalprojsoc_nios2_gen2_0_cpu_debug_monitor_mem_if.slave av,
  output logic [31:0] MonDReg,
  output logic        monitor_ready,
  output logic        monitor_error
);
  state_t            state;
  logic [RAM_AW-1:0] MonAReg;
  logic              slot_vld, slot_wr, rd_done, overrun;
  logic              rd_reg_page;
  logic [31:0]       reg_q, reg_rd, ram_q;
  ram_req_t          ram_req;
  logic              req_rd, req_wr, busy, accept, drop, cpu_ok, cpu_rd, cpu_wr;

  wire unused_jdo = &{1'b0, jdo[37:35], jdo[2:0]};

  assign req_rd = (take_action_ocimem_a && jdo[JDO_RD_REQ]) || take_no_action_ocimem_a;
  assign req_wr = take_action_ocimem_b;
  // a read completion still owns MonAReg/MonDReg, so it blocks new commands too
  assign busy   = slot_vld || rd_done;
  assign accept = (req_rd || req_wr) && !busy;
  assign drop   = (req_rd || req_wr) && busy;
  // CPU only gets the RAM in IDLE when no JTAG command is pending or arriving
  assign cpu_ok = (state == IDLE) && !slot_vld && !accept;
  assign cpu_rd = cpu_ok && av.av_read;
  assign cpu_wr = cpu_ok && av.av_write && !av.av_read;

  // register page read mux
  always_comb begin
    reg_rd = '0;
    case (av.av_address[1:0])
      REG_STATUS: reg_rd = {29'b0, overrun, monitor_error, monitor_ready};
      REG_ADDR:   reg_rd = {{(32-RAM_AW){1'b0}}, MonAReg};
      default:    reg_rd = '0;
    endcase
  end

  // RAM port steering: JTAG states own it, otherwise the CPU in IDLE
  always_comb begin
    ram_req = '0;
    case (state)
      J_RD: begin
        ram_req.re   = 1'b1;
        ram_req.addr = MonAReg;
      end
      J_WR: begin
        ram_req.we    = 1'b1;
        ram_req.be    = '1;
        ram_req.addr  = MonAReg;
        ram_req.wdata = MonDReg;
      end
      default: begin
        ram_req.addr  = av.av_address[RAM_AW-1:0];
        ram_req.be    = av.av_byteenable;
        ram_req.wdata = av.av_writedata;
        ram_req.re    = cpu_rd && !av.av_address[8];
        ram_req.we    = cpu_wr && !av.av_address[8];
      end
    endcase
    if (reset) ram_req.we = 1'b0;
  end

  finalprojsoc_nios2_gen2_0_cpu_debug_monitor_ram #(.AW(RAM_AW)) u_ram (
    .clk   (clk),
    .we    (ram_req.we),
    .re    (ram_req.re),
    .be    (ram_req.be),
    .addr  (ram_req.addr),
    .wdata (ram_req.wdata),
    .q     (ram_q)
  );

  assign av.av_readdata    = (state == C_RD) ? (rd_reg_page ? reg_q : ram_q) : '0;
  assign av.av_waitrequest = reset ||
    ((state != C_RD) && ((state != IDLE) || slot_vld || accept || av.av_read));

  // FSM, pending slot, JTAG registers and status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      MonAReg       <= '0;
      MonDReg       <= '0;
      slot_vld      <= 1'b0;
      slot_wr       <= 1'b0;
      rd_done       <= 1'b0;
      overrun       <= 1'b0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
      rd_reg_page   <= 1'b0;
      reg_q         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (slot_vld)    state <= slot_wr ? J_WR : J_RD;
          else if (accept) state <= req_wr ? J_WR : J_RD;
          else if (cpu_rd) state <= C_RD;
        end
        default: state <= IDLE;
      endcase

      rd_done <= (state == J_RD);
      if (state == J_RD || state == J_WR) slot_vld <= 1'b0;
      if (accept) begin
        slot_vld <= 1'b1;
        slot_wr  <= req_wr;
      end

      if (cpu_rd) begin
        rd_reg_page <= av.av_address[8];
        reg_q       <= reg_rd;
      end

      // CPU status writes first so a same-cycle JTAG clear overrides
      if (cpu_wr && av.av_address[8] && av.av_address[1:0] == REG_STATUS) begin
        if (av.av_writedata[0]) monitor_ready <= 1'b1;
        if (av.av_writedata[1]) monitor_error <= 1'b1;
        if (av.av_writedata[2]) overrun       <= 1'b0;
      end
      if (drop) overrun <= 1'b1;

      if (take_action_ocimem_a && !drop) begin
        MonAReg <= jdo[JDO_ADDR_LSB +: RAM_AW];
        if (jdo[JDO_RDY_CLR]) monitor_ready <= 1'b0;
        if (jdo[JDO_ERR_CLR]) monitor_error <= 1'b0;
      end
      if (take_action_ocimem_b && !busy) MonDReg <= jdo[JDO_DATA_MSB:JDO_DATA_LSB];

      if (state == J_WR) MonAReg <= MonAReg + RAM_AW'(1);
      if (rd_done) begin
        MonDReg <= ram_q;
        MonAReg <= MonAReg + RAM_AW'(1);
      end
    end
  end
endmodule

// File: tb/tb_finalprojsoc_nios2_gen2_0_cpu_debug_monitor_mem.sv
// Scoreboard bench for the debug monitor memory stage.
module tb_finalprojsoc_nios2_gen2_0_cpu_debug_monitor_mem;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [37:0] jdo = '0;
  logic        ta_a = 1'b0, tna_a = 1'b0, ta_b = 1'b0;
  logic [31:0] mon_d;
  logic        mon_rdy, mon_err;
  int          n_tests = 0, n_fail = 0;
  int          nw;
  logic [31:0] mem_m [256];
  logic [31:0] sb_q [$];
  logic [31:0] jq [$];

  finalprojsoc_nios2_gen2_0_cpu_debug_monitor_mem_if av_if ();

  finalprojsoc_nios2_gen2_0_cpu_debug_monitor_mem #(.RAM_AW(8)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (ta_a),
    .take_no_action_ocimem_a (tna_a),
    .take_action_ocimem_b    (ta_b),
    .av                      (av_if.slave),
    .MonDReg                 (mon_d),
    .monitor_ready           (mon_rdy),
    .monitor_error           (mon_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [37:0] jdo_a(input logic [7:0] ad, input logic rc, input logic ec,
                                        input logic rd);
    logic [37:0] j;
    j = '0;
    j[33:26] = ad; j[25] = rc; j[24] = ec; j[17] = rd;
    return j;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  task automatic cpu_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] be,
                           output int n);
    n = 0;
    tick();
    av_if.av_address = a; av_if.av_writedata = d; av_if.av_byteenable = be; av_if.av_write = 1'b1;
    @(negedge clk);
    while (av_if.av_waitrequest && n < 16) begin n++; @(negedge clk); end
    if (n >= 16) chk("wr_timeout", 32'(n), 32'd0);
    tick();
    av_if.av_write = 1'b0;
    if (!a[8]) for (int i = 0; i < 4; i++) if (be[i]) mem_m[a[7:0]][8*i +: 8] = d[8*i +: 8];
  endtask

  task automatic cpu_read(input string tag, input logic [8:0] a, input logic [31:0] exp,
                          input int exp_wait);
    int n = 0;
    logic [31:0] d;
    sb_q.push_back(exp);
    tick();
    av_if.av_address = a; av_if.av_read = 1'b1;
    @(negedge clk);
    while (av_if.av_waitrequest && n < 16) begin n++; @(negedge clk); end
    d = av_if.av_readdata;
    tick();
    av_if.av_read = 1'b0;
    chk({tag, "_data"}, d, sb_q.pop_front());
    chk({tag, "_wait"}, 32'(n), 32'(exp_wait));
  endtask

  // kind: 0 = take_action_a, 1 = take_no_action_a, 2 = take_action_b
  task automatic jpulse(input int kind, input logic [37:0] j);
    tick();
    jdo = j;
    case (kind)
      0: ta_a = 1'b1;
      1: tna_a = 1'b1;
      default: ta_b = 1'b1;
    endcase
    tick();
    ta_a = 1'b0; tna_a = 1'b0; ta_b = 1'b0;
  endtask

  task automatic jread(input string tag, input int kind, input logic [37:0] j,
                       input logic [31:0] exp);
    jq.push_back(exp);
    jpulse(kind, j);
    repeat (3) tick();
    chk(tag, mon_d, jq.pop_front());
  endtask

  initial begin
    av_if.av_address = '0; av_if.av_read = 1'b0; av_if.av_write = 1'b0;
    av_if.av_writedata = '0; av_if.av_byteenable = '0;
    for (int i = 0; i < 256; i++) mem_m[i] = '0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_wait", 32'(av_if.av_waitrequest), 32'd1);
    chk("rst_mond", mon_d, 32'd0);
    chk("rst_rdy", 32'(mon_rdy), 32'd0);
    chk("rst_err", 32'(mon_err), 32'd0);
    chk("rst_rdata", av_if.av_readdata, 32'd0);
    tick();
    reset = 1'b0;
    cpu_read("rst_reg0", 9'h100, 32'd0, 1);
    cpu_read("rst_reg1", 9'h101, 32'd0, 1);

    // JTAG write then read back
    jpulse(0, jdo_a(8'h10, 1'b0, 1'b0, 1'b0));
    jpulse(2, jdo_b(32'hDEADBEEF));
    mem_m[8'h10] = 32'hDEADBEEF;
    repeat (3) tick();
    cpu_read("jwr_areg_after_wr", 9'h101, 32'h11, 1);
    jread("jwr_rd", 0, jdo_a(8'h10, 1'b0, 1'b0, 1'b1), mem_m[8'h10]);
    cpu_read("jwr_areg", 9'h101, 32'h11, 1);
    cpu_read("jwr_cpu", 9'h010, 32'hDEADBEEF, 1);

    // wrap-around
    cpu_write(9'h0FF, 32'h0BADF00D, 4'hF, nw);
    cpu_write(9'h000, 32'hA5A50000, 4'hF, nw);
    cpu_write(9'h001, 32'h11112222, 4'hF, nw);
    jread("wrap_ff", 0, jdo_a(8'hFF, 1'b0, 1'b0, 1'b1), mem_m[255]);
    cpu_read("wrap_areg", 9'h101, 32'h0, 1);
    jread("wrap_next", 1, '0, mem_m[0]);
    cpu_read("wrap_areg1", 9'h101, 32'h1, 1);

    // CPU byte-enable write and read latency
    cpu_write(9'h004, 32'hFFFFFFFF, 4'hF, nw);
    chk("cwr_wait", 32'(nw), 32'd0);
    cpu_write(9'h004, 32'h12345678, 4'b0011, nw);
    cpu_read("cpu_be", 9'h004, 32'hFFFF5678, 1);
    cpu_read("cpu_be_model", 9'h004, mem_m[4], 1);

    // collision: JTAG read-next alongside av_read, then a second pulse a cycle later
    jq.push_back(mem_m[1]);
    fork
      cpu_read("col_cpu", 9'h004, 32'hFFFF5678, 3);
      begin
        tick();
        tna_a = 1'b1;
        tick();
        tick();
        tna_a = 1'b0;
      end
    join
    chk("col_mond", mon_d, jq.pop_front());
    cpu_read("col_reg0", 9'h100, 32'h4, 1);
    cpu_read("col_areg", 9'h101, 32'h2, 1);
    cpu_write(9'h100, 32'h4, 4'hF, nw);
    cpu_read("ovr_clr", 9'h100, 32'h0, 1);

    // status flags
    cpu_write(9'h100, 32'h3, 4'hF, nw);
    chk("flg_rdy_set", 32'(mon_rdy), 32'd1);
    chk("flg_err_set", 32'(mon_err), 32'd1);
    cpu_read("flg_reg0", 9'h100, 32'h3, 1);
    jpulse(0, jdo_a(8'h20, 1'b1, 1'b0, 1'b0));
    chk("flg_rdy_clr", 32'(mon_rdy), 32'd0);
    chk("flg_err_kept", 32'(mon_err), 32'd1);
    fork
      cpu_write(9'h100, 32'h1, 4'hF, nw);
      jpulse(0, jdo_a(8'h20, 1'b1, 1'b0, 1'b0));
    join
    chk("flg_clr_wins", 32'(mon_rdy), 32'd0);
    cpu_read("flg_reg0b", 9'h100, 32'h2, 1);
    jpulse(0, jdo_a(8'h20, 1'b0, 1'b1, 1'b0));
    chk("flg_err_clr", 32'(mon_err), 32'd0);

    // reset in the middle of a JTAG write
    cpu_write(9'h030, 32'hCAFE0030, 4'hF, nw);
    cpu_write(9'h100, 32'h3, 4'hF, nw);
    jpulse(0, jdo_a(8'h30, 1'b0, 1'b0, 1'b0));
    tick();
    jdo = jdo_b(32'h55555555);
    ta_b = 1'b1;
    tick();
    ta_b = 1'b0;
    chk("jwr_busy", 32'(av_if.av_waitrequest), 32'd1);
    chk("jwr_mond", mon_d, 32'h55555555);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_wait", 32'(av_if.av_waitrequest), 32'd1);
    chk("mid_rst_mond", mon_d, 32'd0);
    chk("mid_rst_rdy", 32'(mon_rdy), 32'd0);
    chk("mid_rst_err", 32'(mon_err), 32'd0);
    chk("mid_rst_rdata", av_if.av_readdata, 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    cpu_read("mid_rst_ram", 9'h030, 32'hCAFE0030, 1);
    cpu_read("mid_rst_reg0", 9'h100, 32'h0, 1);
    cpu_read("mid_rst_reg1", 9'h101, 32'h0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
